// File: rtl/rsa_modexp.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_modexp
//  Description : C = M^E mod P using Montgomery arithmetic (R = 2^WIDTH).
//                A bit-serial Montgomery multiplier runs one MontMul at a
//                time; an FSM sequences left-to-right square-and-multiply.
//                Optional parameter check enabled by `define RSA_PARAM_CHECK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module rsa_modexp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start_cmd,
    input  logic             stop_cmd,
    input  logic [WIDTH-1:0] rsa_p,
    input  logic [WIDTH-1:0] rsa_e,
    input  logic [WIDTH-1:0] rsa_m,
    input  logic [WIDTH-1:0] rsa_const,
    output logic [WIDTH-1:0] rsa_c,
    output logic             eoc,
    output logic             busy,
    output logic             err
);

    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    C_LAST = CW'(WIDTH);
    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE_M = 3'd1,
        S_PRE_X = 3'd2,
        S_SQR   = 3'd3,
        S_MUL   = 3'd4,
        S_POST  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [IW-1:0]    idx_q,   idx_d;
    logic [AW-1:0]    a_q,     a_d;
    logic [WIDTH-1:0] x_q,     x_d;
    logic [WIDTH-1:0] mb_q,    mb_d;
    logic [WIDTH-1:0] p_q,     p_d;
    logic [WIDTH-1:0] e_q,     e_d;
    logic [WIDTH-1:0] m_q,     m_d;
    logic [WIDTH-1:0] k_q,     k_d;
    logic [WIDTH-1:0] rsa_c_q, rsa_c_d;

    logic [WIDTH-1:0] op_x, op_y;
    logic             w_xbit;
    logic [AW-1:0]    w_pext;
    logic [AW-1:0]    w_sum;
    logic [AW-1:0]    w_sum_odd;
    logic [AW-1:0]    w_step;
    logic [WIDTH-1:0] w_res;
    logic             w_last;
    logic             w_start;

`ifdef RSA_PARAM_CHECK_EN
    logic err_q, err_d;
    logic w_bad;
    // Invalid modulus or pre-computed constant is flagged at start time.
    assign w_bad = ~rsa_p[0] | (rsa_p <= C_ONE) | (rsa_const >= rsa_p);
    assign err   = err_q;
`else
    assign err   = 1'b0;
`endif

    // Operand selection for the MontMul of the current phase; operands are
    // stable for the whole multiplication since X/Mb only update on its last cycle.
    always_comb begin
        op_x = x_q;
        op_y = x_q;
        case (state_q)
            S_PRE_M: begin op_x = m_q;   op_y = k_q;  end
            S_PRE_X: begin op_x = C_ONE; op_y = k_q;  end
            S_MUL:   begin op_y = mb_q;               end
            S_POST:  begin op_y = C_ONE;              end
            default: ;
        endcase
    end

    // One bit-serial Montgomery iteration plus the final conditional subtract.
    assign w_xbit    = |(op_x & (C_ONE << cnt_q));
    assign w_pext    = {2'b00, p_q};
    assign w_sum     = a_q + (w_xbit ? {2'b00, op_y} : {AW{1'b0}});
    assign w_sum_odd = w_sum + (w_sum[0] ? w_pext : {AW{1'b0}});
    assign w_step    = w_sum_odd >> 1;
    assign w_res     = WIDTH'((a_q >= w_pext) ? (a_q - w_pext) : a_q);
    assign w_last    = (cnt_q == C_LAST);
    assign w_start   = start_cmd & ~stop_cmd;

    assign rsa_c = rsa_c_q;
    assign eoc   = (state_q == S_DONE);
    assign busy  = (state_q != S_IDLE) && (state_q != S_DONE);

    // Next-state and datapath update logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        a_d     = a_q;
        x_d     = x_q;
        mb_d    = mb_q;
        p_d     = p_q;
        e_d     = e_q;
        m_d     = m_q;
        k_d     = k_q;
        rsa_c_d = rsa_c_q;
`ifdef RSA_PARAM_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    p_d     = rsa_p;
                    e_d     = rsa_e;
                    m_d     = rsa_m;
                    k_d     = rsa_const;
                    cnt_d   = '0;
                    a_d     = '0;
                    state_d = S_PRE_M;
`ifdef RSA_PARAM_CHECK_EN
                    err_d   = 1'b0;
                    if (w_bad) begin
                        state_d = S_DONE;
                        rsa_c_d = '0;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                if (stop_cmd) begin
                    // Abort: drop the partial result, leave rsa_c untouched.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    a_d     = '0;
                end else if (!w_last) begin
                    a_d   = w_step;
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    a_d   = '0;
                    cnt_d = '0;
                    case (state_q)
                        S_PRE_M: begin
                            mb_d    = w_res;
                            state_d = S_PRE_X;
                        end
                        S_PRE_X: begin
                            x_d     = w_res;
                            idx_d   = IW'(WIDTH - 1);
                            state_d = S_SQR;
                        end
                        S_SQR: begin
                            x_d = w_res;
                            if (e_q[idx_q]) begin
                                state_d = S_MUL;
                            end else if (idx_q == '0) begin
                                state_d = S_POST;
                            end else begin
                                idx_d = idx_q - IW'(1);
                            end
                        end
                        S_MUL: begin
                            x_d = w_res;
                            if (idx_q == '0) begin
                                state_d = S_POST;
                            end else begin
                                idx_d   = idx_q - IW'(1);
                                state_d = S_SQR;
                            end
                        end
                        S_POST: begin
                            x_d     = w_res;
                            rsa_c_d = w_res;
                            state_d = S_DONE;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // FSM state register, frozen while ena is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    // Datapath and operand registers, frozen while ena is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            a_q     <= '0;
            x_q     <= '0;
            mb_q    <= '0;
            p_q     <= '0;
            e_q     <= '0;
            m_q     <= '0;
            k_q     <= '0;
            rsa_c_q <= '0;
        end else if (ena) begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            x_q     <= x_d;
            mb_q    <= mb_d;
            p_q     <= p_d;
            e_q     <= e_d;
            m_q     <= m_d;
            k_q     <= k_d;
            rsa_c_q <= rsa_c_d;
        end
    end

`ifdef RSA_PARAM_CHECK_EN
    // Sticky parameter-error flag, cleared by the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (ena) begin
            err_q <= err_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rsa_modexp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rsa_modexp
//  Description : Self-checking bench for rsa_modexp (WIDTH=8): directed
//                vector table, randomized runs against a modular-power model,
//                and hand-written stop / ena / reset / parameter-check cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rsa_modexp;

    localparam int W     = 8;
    localparam int BOUND = 3000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ena = 1'b1;
    logic         start_cmd = 1'b0;
    logic         stop_cmd = 1'b0;
    logic [W-1:0] rsa_p = '0, rsa_e = '0, rsa_m = '0, rsa_const = '0;
    logic [W-1:0] rsa_c;
    logic         eoc, busy, err;

    int n_checks = 0;
    int n_fail   = 0;

    rsa_modexp #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .start_cmd (start_cmd),
        .stop_cmd  (stop_cmd),
        .rsa_p     (rsa_p),
        .rsa_e     (rsa_e),
        .rsa_m     (rsa_m),
        .rsa_const (rsa_const),
        .rsa_c     (rsa_c),
        .eoc       (eoc),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] p, e, m, k;
        logic [W-1:0] c;
        int           lat;
    } vec_t;

    vec_t tbl[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain modular exponentiation.
    function automatic longint modpow(input longint p, input longint e, input longint m);
        longint r = 1 % p;
        longint b = m % p;
        longint x = e;
        while (x > 0) begin
            if (x[0]) r = (r * b) % p;
            b = (b * b) % p;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic int exp_lat(input logic [W-1:0] e);
        return (3 + W + $countones(e)) * (W + 1) + 1;
    endfunction

    // Launch one computation and wait (bounded) for eoc.
    task automatic run_op(input logic [W-1:0] p, e, m, k,
                          output int lat, output logic [W-1:0] c, output bit busy_ok);
        rsa_p = p; rsa_e = e; rsa_m = m; rsa_const = k;
        start_cmd = 1'b1;
        tick();
        start_cmd = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!eoc && lat < BOUND) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            lat++;
        end
        c = rsa_c;
    endtask

    // Count eoc pulses over a number of cycles.
    task automatic watch_eoc(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (eoc) seen++;
            tick();
        end
    endtask

    initial begin
        int           lat, seen;
        logic [W-1:0] c;
        bit           bok;
        logic [W-1:0] p, e, m, k;

        tbl[0] = '{p:8'd187, e:8'd7,   m:8'd88,  k:8'd86, c:8'd11, lat:127};
        tbl[1] = '{p:8'd187, e:8'd0,   m:8'd88,  k:8'd86, c:8'd1,  lat:100};
        tbl[2] = '{p:8'd187, e:8'd1,   m:8'd200, k:8'd86, c:8'd13, lat:109};
        tbl[3] = '{p:8'd255, e:8'd5,   m:8'd0,   k:8'd1,  c:8'd0,  lat:118};
        tbl[4] = '{p:8'd3,   e:8'd255, m:8'd2,   k:8'd1,  c:8'd2,  lat:172};

        // Reset state
        rst = 1'b1;
        tick(); tick();
        chk("reset_rsa_c", rsa_c, 0);
        chk("reset_eoc",   eoc,   0);
        chk("reset_busy",  busy,  0);
        chk("reset_err",   err,   0);
        rst = 1'b0;
        tick();

        // Directed vector table
        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i].p, tbl[i].e, tbl[i].m, tbl[i].k, lat, c, bok);
            chk($sformatf("tbl%0d_c", i),    c,    tbl[i].c);
            chk($sformatf("tbl%0d_lat", i),  lat,  tbl[i].lat);
            chk($sformatf("tbl%0d_busy", i), bok,  1);
            chk($sformatf("tbl%0d_busy_at_eoc", i), busy, 0);
            tick();
        end

        // Randomized runs against the model
        for (int i = 0; i < 20; i++) begin
            p = 8'($urandom_range(1, 127) * 2 + 1);
            e = 8'($urandom_range(0, 255));
            m = 8'($urandom_range(0, 255));
            k = 8'(65536 % int'(p));
            run_op(p, e, m, k, lat, c, bok);
            chk($sformatf("rnd%0d_c(p=%0d e=%0d m=%0d)", i, p, e, m), c, modpow(p, e, m));
            chk($sformatf("rnd%0d_lat", i), lat, exp_lat(e));
            tick();
        end

        // Stop mid-run: rsa_c keeps previous value (13), no eoc
        run_op(8'd187, 8'd1, 8'd200, 8'd86, lat, c, bok);
        chk("stop_pre_c", c, 13);
        tick();
        rsa_p = 8'd187; rsa_e = 8'd7; rsa_m = 8'd88; rsa_const = 8'd86;
        start_cmd = 1'b1;
        tick();
        start_cmd = 1'b0;
        watch_eoc(39, seen);
        stop_cmd = 1'b1;
        tick();
        stop_cmd = 1'b0;
        chk("stop_busy_low", busy, 0);
        watch_eoc(200, lat);
        chk("stop_no_eoc", seen + lat, 0);
        chk("stop_rsa_c_kept", rsa_c, 13);
        run_op(8'd187, 8'd7, 8'd88, 8'd86, lat, c, bok);
        chk("stop_restart_c",   c,   11);
        chk("stop_restart_lat", lat, 127);
        tick();

        // ena low for 20 cycles, extra starts while busy, rsa_m changed mid-run
        rsa_p = 8'd187; rsa_e = 8'd7; rsa_m = 8'd88; rsa_const = 8'd86;
        start_cmd = 1'b1;
        tick();
        start_cmd = 1'b0;
        lat = 1;
        for (int i = 1; i < 30; i++) begin
            start_cmd = (i == 10 || i == 20);
            if (i == 12) rsa_m = 8'd5;
            tick();
            lat++;
        end
        start_cmd = 1'b0;
        ena = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) start_cmd = 1'b1;
            if (i == 6) start_cmd = 1'b0;
            tick();
            lat++;
        end
        ena = 1'b1;
        while (!eoc && lat < BOUND) begin
            tick();
            lat++;
        end
        chk("ena_lat",   lat,   147);
        chk("ena_rsa_c", rsa_c, 11);
        tick();
        rsa_m = 8'd88;

        // Reset mid-run
        rsa_p = 8'd187; rsa_e = 8'd7; rsa_m = 8'd88; rsa_const = 8'd86;
        start_cmd = 1'b1;
        tick();
        start_cmd = 1'b0;
        watch_eoc(59, seen);
        rst = 1'b1;
        #1;
        chk("rst_mid_rsa_c", rsa_c, 0);
        chk("rst_mid_busy",  busy,  0);
        tick();
        rst = 1'b0;
        watch_eoc(150, lat);
        chk("rst_mid_no_eoc", seen + lat, 0);

        // start and stop together in IDLE: stop wins
        start_cmd = 1'b1;
        stop_cmd  = 1'b1;
        tick();
        start_cmd = 1'b0;
        stop_cmd  = 1'b0;
        chk("start_stop_idle_busy", busy, 0);
        watch_eoc(150, seen);
        chk("start_stop_idle_no_eoc", seen, 0);

`ifdef RSA_PARAM_CHECK_EN
        // Invalid P: immediate DONE with err
        run_op(8'd186, 8'd7, 8'd88, 8'd86, lat, c, bok);
        chk("pchk_lat",   lat, 1);
        chk("pchk_rsa_c", c,   0);
        tick();
        chk("pchk_err",   err, 1);
        run_op(8'd187, 8'd7, 8'd88, 8'd86, lat, c, bok);
        chk("pchk_clear_err", err, 0);
        chk("pchk_valid_c",   c,   11);
        tick();
`else
        // Without the check, err never rises even for an even modulus
        run_op(8'd186, 8'd7, 8'd88, 8'd86, lat, c, bok);
        chk("nochk_lat", lat, 127);
        chk("nochk_err", err, 0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
